decode_stage: RTL
=================

# decode_stage

Registered instruction-decode stage sitting directly downstream of the instruction fetch unit. It captures each fetched instruction word and PC, decodes the opcode/funct into the control flags and fields the fetch unit and datapath consume: Jump, TargetInstr, JumpReg, Branch, InvZero, imm16, register selects and ALU op. It also detects load-use hazards, inserting one bubble and requesting a one-cycle fetch hold. It honours a flush from the branch/jump resolution logic.

## Interface
- ALUOP_W, 3: width of alu_op encoding
- HAZARD_EN, 1: 1 enables load-use detection; 0 never stalls
- clk  input  1  clock, all state on posedge
- rst_n  input  1  asynchronous, active-low reset
- Instruction  input  32  word from instruction memory
- PCin  input  30  word address of Instruction
- flush  input  1  squash the instruction being captured this edge
- stall_req  output  1  registered; fetch must hold PC and Instruction for the next cycle
- valid  output  1  decoded outputs describe a real instruction
- PCout  output  30  PC of the decoded instruction
- Jump, JumpReg, Branch, InvZero  output  1 each  fetch-unit control
- TargetInstr  output  26  Instruction[25:0]
- imm16  output  16  Instruction[15:0]
- rs, rt, wreg  output  5 each  source regs; write destination
- RegWrite, MemRead, MemWrite, ALUSrcImm, ZeroExt  output  1 each  datapath control
- alu_op  output  ALUOP_W  0 add, 1 sub, 2 slt, 3 xor
- illegal  output  1  unsupported opcode/funct

## Operation
- Decode table, op = Instruction[31:26], funct = [5:0]:
  - R-type (op 0x00): funct 0x20 add, 0x22 sub, 0x2A slt → RegWrite, wreg = rd. Funct 0x08 jr → JumpReg, no RegWrite.
  - lw 0x23: MemRead, RegWrite, ALUSrcImm, add, wreg = rt.
  - sw 0x2B: MemWrite, ALUSrcImm, add.
  - beq 0x04: Branch, InvZero = 0, sub. bne 0x05: Branch, InvZero = 1, sub.
  - j 0x02: Jump. jal 0x03: Jump, RegWrite, wreg = 31.
  - addi 0x08: RegWrite, ALUSrcImm, add, wreg = rt. xori 0x0E: adds ZeroExt and xor.
  - Anything else: illegal = 1, valid = 0, all control flags 0.
- Bubble: valid = 0 and every control flag 0. Fields (rs, rt, imm16, TargetInstr, PCout) hold their last values.
- FSM, two states:
  - RUN: normal capture and decode.
  - HOLD: entered when the instruction now in the output register has MemRead = 1 and its wreg ≠ 0 equals the incoming rs, or equals the incoming rt for R-type, beq, bne or sw. On entry, stall_req = 1 and the outputs are a bubble. The incoming word is kept in an internal hold register.
  - HOLD always returns to RUN after exactly one cycle, decoding the held word. stall_req = 0 there.
- flush has priority over everything. On the edge, the outputs become a bubble, any HOLD is cancelled, state returns to RUN and stall_req = 0.
- Reset: state RUN. All outputs 0, including valid, stall_req, illegal and PCout.

## Timing
- Latency 1 cycle: Instruction/PCin sampled at posedge N appear decoded after posedge N.
- A load-use pair costs exactly one bubble cycle. Back-to-back lw → lw → dependent instruction stalls only on the last dependence.
- stall_req is high for exactly one cycle per hazard and is never asserted two consecutive cycles.
- flush and a hazard on the same edge: the flush wins and there is no stall.
- Reset asserted mid-HOLD: immediate bubble and RUN. The held word is discarded.
- Branches and jumps are decoded only. Resolution and flush generation are external.

## Structure
- Shared package: opcode/funct constants, alu_op encodings, the bubble control bundle and the REG_RA = 31 constant.
- One sub-module, instr_decoder: purely combinational word → control bundle. decode_stage holds the registers, the hold buffer and the FSM.

## Test plan
- Reset, then 0x01295020 (add $10,$9,$9) → next cycle: valid = 1, RegWrite = 1, rs = 9, rt = 9, wreg = 10, alu_op = 0.
- 0x8D090000 (lw $9,0($8)) then 0x01295020 → one bubble with stall_req = 1, then add decoded with valid = 1. A non-dependent word after lw causes no stall.
- 0x10000003, then 0x14000003 → Branch = 1, imm16 = 3, InvZero = 0 for the first and 1 for the second.
- 0x08000009 → Jump = 1, TargetInstr = 9. 0x0C000009 → Jump = 1, RegWrite = 1, wreg = 31. 0x03E00008 → JumpReg = 1, rs = 31.
- Hazard pair with flush on the stall edge → bubble, stall_req = 0, state RUN. Separately, 0xFC000000 → illegal = 1, valid = 0.
- rst_n pulsed low asynchronously during HOLD → all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: opcode/funct constants, ALU encodings and the decoded control bundle.
package decode_stage_pkg;
    localparam int ALU_W = 3;
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_XORI = 6'h0E, OP_LW = 6'h23,
                           OP_SW = 6'h2B;
    localparam logic [5:0] F_JR = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22, F_SLT = 6'h2A;
    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [ALU_W-1:0] {ALU_ADD, ALU_SUB, ALU_SLT, ALU_XOR} alu_op_t;

    typedef struct packed {
        logic    valid;
        logic    illegal;
        logic    jump;
        logic    jump_reg;
        logic    branch;
        logic    inv_zero;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src_imm;
        logic    zero_ext;
        alu_op_t alu_op;
        logic [4:0] wreg;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Instructions whose rt field is a source operand
    function automatic logic uses_rt(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_BEQ || op == OP_BNE || op == OP_SW;
    endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side inputs and decoded outputs of the decode stage.
interface decode_stage_if #(parameter int ALUOP_W = 3);
    logic [31:0] Instruction;
    logic [29:0] PCin, PCout;
    logic flush, stall_req, valid, illegal;
    logic Jump, JumpReg, Branch, InvZero;
    logic [25:0] TargetInstr;
    logic [15:0] imm16;
    logic [4:0] rs, rt, wreg;
    logic RegWrite, MemRead, MemWrite, ALUSrcImm, ZeroExt;
    logic [ALUOP_W-1:0] alu_op;

    modport master (
        output Instruction, PCin, flush,
        input  stall_req, valid, illegal, PCout, Jump, JumpReg, Branch, InvZero, TargetInstr,
               imm16, rs, rt, wreg, RegWrite, MemRead, MemWrite, ALUSrcImm, ZeroExt, alu_op
    );
    modport slave (
        input  Instruction, PCin, flush,
        output stall_req, valid, illegal, PCout, Jump, JumpReg, Branch, InvZero, TargetInstr,
               imm16, rs, rt, wreg, RegWrite, MemRead, MemWrite, ALUSrcImm, ZeroExt, alu_op
    );
endinterface

// File: rtl/decode_stage_instr_decoder.sv
// instr_decoder: combinational opcode/funct to control bundle decode.
module instr_decoder
    import decode_stage_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = CTRL_BUBBLE;
        ctrl.valid = 1'b1;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.wreg = rd;
                case (funct)
                    F_ADD: ctrl.alu_op = ALU_ADD;
                    F_SUB: ctrl.alu_op = ALU_SUB;
                    F_SLT: ctrl.alu_op = ALU_SLT;
                    F_JR: begin
                        ctrl.reg_write = 1'b0;
                        ctrl.wreg = 5'd0;
                        ctrl.jump_reg = 1'b1;
                    end
                    default: begin
                        ctrl = CTRL_BUBBLE;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.mem_read = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.wreg = rt;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src_imm = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.branch = 1'b1;
                ctrl.inv_zero = op == OP_BNE;
                ctrl.alu_op = ALU_SUB;
            end
            OP_J: ctrl.jump = 1'b1;
            OP_JAL: begin
                ctrl.jump = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.wreg = REG_RA;
            end
            OP_ADDI, OP_XORI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.wreg = rt;
                ctrl.zero_ext = op == OP_XORI;
                ctrl.alu_op = op == OP_XORI ? ALU_XOR : ALU_ADD;
            end
            default: begin
                ctrl = CTRL_BUBBLE;
                ctrl.illegal = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode with load-use bubble insertion and flush.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int ALUOP_W   = 3,
    parameter bit HAZARD_EN = 1'b1
) (
    input logic clk,
    input logic rst_n,
    decode_stage_if.slave bus
);
    typedef enum logic {RUN, HOLD} state_t;
    state_t state, state_next;
    logic [31:0] hold_instr, word;
    logic [29:0] hold_pc, pc, pc_q;
    logic [4:0] rs_q, rt_q;
    logic [15:0] imm_q;
    logic [25:0] tgt_q;
    logic stall_q, hazard;
    ctrl_t dec, ctrl_q;

    instr_decoder u_dec (
        .op(word[31:26]), .funct(word[5:0]), .rt(word[20:16]), .rd(word[15:11]), .ctrl(dec)
    );

    // In HOLD the word parked on the stall edge is decoded instead of the fetch input
    always_comb begin
        word = state == HOLD ? hold_instr : bus.Instruction;
        pc = state == HOLD ? hold_pc : bus.PCin;
        hazard = HAZARD_EN && state == RUN && ctrl_q.mem_read && ctrl_q.wreg != 5'd0 &&
                 (ctrl_q.wreg == word[25:21] || (uses_rt(word[31:26]) && ctrl_q.wreg == word[20:16]));
        state_next = hazard && !bus.flush ? HOLD : RUN;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= RUN;
        else state <= state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_BUBBLE;
            stall_q <= 1'b0;
            rs_q <= '0;
            rt_q <= '0;
            imm_q <= '0;
            tgt_q <= '0;
            pc_q <= '0;
            hold_instr <= '0;
            hold_pc <= '0;
        end else begin
            stall_q <= state_next == HOLD;
            if (hazard) begin
                hold_instr <= word;
                hold_pc <= pc;
            end
            if (bus.flush || hazard) ctrl_q <= CTRL_BUBBLE;
            else begin
                ctrl_q <= dec;
                rs_q <= word[25:21];
                rt_q <= word[20:16];
                imm_q <= word[15:0];
                tgt_q <= word[25:0];
                pc_q <= pc;
            end
        end
    end

    assign bus.stall_req = stall_q;
    assign bus.valid = ctrl_q.valid;
    assign bus.illegal = ctrl_q.illegal;
    assign bus.PCout = pc_q;
    assign bus.Jump = ctrl_q.jump;
    assign bus.JumpReg = ctrl_q.jump_reg;
    assign bus.Branch = ctrl_q.branch;
    assign bus.InvZero = ctrl_q.inv_zero;
    assign bus.TargetInstr = tgt_q;
    assign bus.imm16 = imm_q;
    assign bus.rs = rs_q;
    assign bus.rt = rt_q;
    assign bus.wreg = ctrl_q.wreg;
    assign bus.RegWrite = ctrl_q.reg_write;
    assign bus.MemRead = ctrl_q.mem_read;
    assign bus.MemWrite = ctrl_q.mem_write;
    assign bus.ALUSrcImm = ctrl_q.alu_src_imm;
    assign bus.ZeroExt = ctrl_q.zero_ext;
    assign bus.alu_op = ALUOP_W'(ctrl_q.alu_op);
endmodule
